// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: grant codes, read latency, clear-engine state
// and the per-stage grant pipeline payload.
package vram_arb_pkg;

  localparam int unsigned RD_LAT = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_DL   = 2'd3
  } grant_t;

  typedef enum logic {
    CLR_RUN  = 1'b0,
    CLR_DONE = 1'b1
  } clr_state_t;

  typedef struct packed {
    grant_t gnt;
    logic   we;
  } pipe_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (bit 0 = CPU, bit 1 = download). The pointer
// moves to the other requester only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_c_o = 2'b00;
    ptr_d   = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_c_o = 2'b01;
        2'b10:   gnt_c_o = 2'b10;
        2'b11:   gnt_c_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c_o = 2'b00;
      endcase
      // After a CPU grant the download side gets priority, and vice versa
      if (gnt_c_o != 2'b00) ptr_d = gnt_c_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video > {CPU, download round-robin}, fixed 2-cycle latency.
// Optional hardware clear after reset when VRAM_CLEAR_EN is defined.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_din,
  output logic          dl_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          clear_busy
);

  pipe_t         pipe_q [RD_LAT];
  pipe_t         pipe_d0;
  grant_t        gnt_c;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dl_ack_q, dl_ack_d;
  logic          cpu_busy_c, dl_busy_c;
  logic [1:0]    rr_gnt_c;
  logic          clr_active_c;
  logic [AW-1:0] clr_addr_c;

`ifdef VRAM_CLEAR_EN
  clr_state_t    clr_state_q, clr_state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  // Clear engine: one zero write per cycle, paused whenever video owns the port
  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    if (clr_state_q == CLR_RUN && !vid_req) begin
      clr_addr_d = clr_addr_q + AW'(1);
      if (clr_addr_q == {AW{1'b1}}) clr_state_d = CLR_DONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clr_state_q <= CLR_RUN;
      clr_addr_q  <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  assign clr_active_c = (clr_state_q == CLR_RUN);
  assign clr_addr_c   = clr_addr_q;
`else
  assign clr_active_c = 1'b0;
  assign clr_addr_c   = '0;
`endif

  assign clear_busy = clr_active_c;

  // A requester is blocked from its grant edge through its ack edge
  always_comb begin
    cpu_busy_c = 1'b0;
    dl_busy_c  = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      if (pipe_q[i].gnt == GNT_CPU) cpu_busy_c = 1'b1;
      if (pipe_q[i].gnt == GNT_DL)  dl_busy_c  = 1'b1;
    end
  end

  rr_arb2 u_rr (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .en_i    (!vid_req && !clr_active_c),
    .req_i   ({dl_req && !dl_busy_c, cpu_req && !cpu_busy_c}),
    .gnt_c_o (rr_gnt_c)
  );

  always_comb begin
    gnt_c      = GNT_NONE;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    if (vid_req) begin
      gnt_c      = GNT_VID;
      ram_addr_d = vid_addr;
    end else if (clr_active_c) begin
      ram_addr_d = clr_addr_c;
      ram_we_d   = 1'b1;
      ram_din_d  = '0;
    end else if (rr_gnt_c[0]) begin
      gnt_c      = GNT_CPU;
      ram_addr_d = cpu_addr;
      ram_we_d   = cpu_we;
      ram_din_d  = cpu_din;
    end else if (rr_gnt_c[1]) begin
      gnt_c      = GNT_DL;
      ram_addr_d = dl_addr;
      ram_we_d   = 1'b1;
      ram_din_d  = dl_din;
    end

    pipe_d0.gnt = gnt_c;
    pipe_d0.we  = ram_we_d;

    // Completion stage: read data from the RAM is valid at this edge
    vid_valid_d = (pipe_q[RD_LAT-1].gnt == GNT_VID);
    vid_data_d  = vid_valid_d ? ram_dout : vid_data_q;
    cpu_ack_d   = (pipe_q[RD_LAT-1].gnt == GNT_CPU);
    cpu_dout_d  = (cpu_ack_d && !pipe_q[RD_LAT-1].we) ? ram_dout : cpu_dout_q;
    dl_ack_d    = (pipe_q[RD_LAT-1].gnt == GNT_DL);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
      dl_ack_q    <= 1'b0;
    end else begin
      pipe_q[0] <= pipe_d0;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      dl_ack_q    <= dl_ack_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign dl_ack    = dl_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency VRAM model.
// Clear-engine checks run when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic          cpu_ack;
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_din;
  logic          dl_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          clear_busy;

  logic [DW-1:0] mem [1<<AW];

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] ord;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .dl_req     (dl_req),
    .dl_addr    (dl_addr),
    .dl_din     (dl_din),
    .dl_ack     (dl_ack),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .clear_busy (clear_busy)
  );

  // VRAM model: synchronous write, 1-cycle read latency
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_clear();
`ifdef VRAM_CLEAR_EN
    int c;
    c = 0;
    while (clear_busy && c < 20000) begin
      tick();
      c++;
    end
    chk("clear_wait", 32'(clear_busy), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; dl_req = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    wait_clear();
  endtask

  // lat = edges from the request-sampling edge until the ack is visible
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] q, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (cpu_ack) break;
    end
    q = cpu_dout;
    cpu_req = 1'b0;
  endtask

  task automatic dl_access(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    dl_req = 1'b1; dl_addr = a; dl_din = d;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (dl_ack) break;
    end
    dl_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q;
    logic [DW-1:0] prev;
    int            lat;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;
    vid_addr = '0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    dl_addr = '0; dl_din = '0; ord = '0;
    do_reset();
`ifndef VRAM_CLEAR_EN
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
`endif
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);

    // 1: video fetch, data valid in the cycle after grant edge + 2
    mem[13'h0123] = 8'hA5;
    vid_req = 1'b1; vid_addr = 13'h0123;
    tick();
    vid_req = 1'b0; vid_addr = 13'h0777;
    chk("vid_t0_valid", 32'(vid_valid), 32'd0);
    tick();
    chk("vid_t1_valid", 32'(vid_valid), 32'd0);
    tick();
    chk("vid_t2_valid", 32'(vid_valid), 32'd1);
    chk("vid_t2_data", 32'(vid_data), 32'hA5);
    tick();
    chk("vid_t3_valid", 32'(vid_valid), 32'd0);

    // 2: CPU write then read at top address
    cpu_access(1'b1, 13'h1FFF, 8'h3C, q, lat);
    chk("cpu_wr_lat", 32'(lat), 32'd3);
    chk("cpu_wr_mem", 32'(mem[13'h1FFF]), 32'h3C);
    cpu_access(1'b0, 13'h1FFF, 8'h00, q, lat);
    chk("cpu_rd_lat", 32'(lat), 32'd3);
    chk("cpu_rd_data", 32'(q), 32'h3C);

    // 3: video and CPU at the same edge; CPU address changed after its grant
    mem[13'h0010] = 8'h5A;
    mem[13'h0011] = 8'hEE;
    mem[13'h0200] = 8'h11;
    vid_req = 1'b1; vid_addr = 13'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    tick();
    vid_req = 1'b0;
    chk("col_t0_ramaddr", 32'(ram_addr), 32'h0200);
    tick();
    cpu_addr = 13'h0011;
    chk("col_t1_ramaddr", 32'(ram_addr), 32'h0010);
    tick();
    chk("col_t2_vid_valid", 32'(vid_valid), 32'd1);
    chk("col_t2_vid_data", 32'(vid_data), 32'h11);
    chk("col_t2_cpu_ack", 32'(cpu_ack), 32'd0);
    tick();
    chk("col_t3_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("col_t3_cpu_dout", 32'(cpu_dout), 32'h5A);
    cpu_req = 1'b0;
    tick();
    chk("col_t4_cpu_ack", 32'(cpu_ack), 32'd0);

    // 5: reset drops an in-flight read; a write presented during reset is ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    tick();
    reset_n = 1'b0; cpu_req = 1'b0;
    tick();
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dl_ack", 32'(dl_ack), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_we2", 32'(ram_we), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    prev = mem[13'h0555];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0555; cpu_din = 8'h77;
    tick();
    cpu_req = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rst_drop_ack", 32'(cpu_ack), 32'd0);
    tick();
    chk("rst_drop_ack2", 32'(cpu_ack), 32'd0);
    chk("rst_wr_ignored", 32'(mem[13'h0555]), 32'(prev));
    wait_clear();

    // 4: CPU and download contend; grants must alternate starting with CPU
    fork
      begin
        int l;
        logic [DW-1:0] qq;
        for (int i = 0; i < 3; i++) begin
          cpu_access(1'b1, 13'h0400 + 13'(i), 8'hC0 + 8'(i), qq, l);
          ord = {ord[4:0], 1'b0};
          chk("rr_cpu_wait", 32'(l <= 4), 32'd1);
          tick();
        end
      end
      begin
        int l;
        for (int i = 0; i < 3; i++) begin
          dl_access(13'h0800 + 13'(i), 8'hD0 + 8'(i), l);
          ord = {ord[4:0], 1'b1};
          chk("rr_dl_wait", 32'(l <= 4), 32'd1);
          tick();
        end
      end
    join
    tick();
    chk("rr_order", 32'(ord), 32'b010101);
    for (int i = 0; i < 3; i++) begin
      chk("rr_cpu_mem", 32'(mem[13'h0400 + 13'(i)]), 32'hC0 + 32'(i));
      chk("rr_dl_mem", 32'(mem[13'h0800 + 13'(i)]), 32'hD0 + 32'(i));
    end

`ifdef VRAM_CLEAR_EN
    // 6: clear after reset, two video cycles in the middle, CPU held off
    begin
      int cnt;
      int nz;
      bit early;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;
      reset_n = 1'b0;
      repeat (2) tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      reset_n = 1'b1;
      cnt = 0; early = 1'b0;
      while (clear_busy && cnt < 20000) begin
        vid_req = (cnt == 100 || cnt == 101);
        vid_addr = 13'h0020;
        tick();
        cnt++;
        if (cpu_ack) early = 1'b1;
      end
      vid_req = 1'b0;
      chk("clr_cycles", 32'(cnt), 32'd8194);
      chk("clr_cpu_held", 32'(early), 32'd0);
      lat = 0;
      while (!cpu_ack && lat < 10) begin
        tick();
        lat++;
      end
      chk("clr_cpu_lat", 32'(lat), 32'd3);
      chk("clr_cpu_dout", 32'(cpu_dout), 32'd0);
      cpu_req = 1'b0;
      tick();
      nz = 0;
      for (int i = 0; i < (1 << AW); i++) if (mem[i] != 8'h00) nz++;
      chk("clr_all_zero", 32'(nz), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
